// File: rtl/srlzr_tx_ctrl_pkg.sv
// rtl/srlzr_tx_ctrl_pkg.sv - state encodings and line-select codes for the serializer frame sequencer
package srlzr_tx_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic [1:0] LINE_MARK  = 2'b00;
    localparam logic [1:0] LINE_SPACE = 2'b01;
    localparam logic [1:0] LINE_DATA  = 2'b10;
    localparam logic [1:0] LINE_PAR   = 2'b11;

    // Line source owned by each state; the registered line_sel follows the next state.
    function automatic logic [1:0] line_code(input state_t s);
        logic [1:0] code;
        code = LINE_MARK;
        case (s)
            ST_START:  code = LINE_SPACE;
            ST_DATA:   code = LINE_DATA;
            ST_PARITY: code = LINE_PAR;
            default:   code = LINE_MARK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/srlzr_baud_gen.sv
// rtl/srlzr_baud_gen.sv - bit-slot counter with sync clear; flags the last and next-to-last slot cycles
module srlzr_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_end,
    output logic pre_end
);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] baud_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt <= '0;
        end else if (clr || baud_cnt == LAST) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

    assign bit_end = (baud_cnt == LAST);
    // pre_end lets the parent register strobes that must land on a slot's final cycle
    assign pre_end = (baud_cnt == PRE);

endmodule

// File: rtl/srlzr_tx_ctrl.sv
// rtl/srlzr_tx_ctrl.sv - frame sequencer driving a PISO; optional parity slot under SRLZR_PARITY_EN
module srlzr_tx_ctrl
    import srlzr_tx_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] piso_data,
    output logic                  LOAD,
    output logic                  shift,
    output logic [1:0]            line_sel,
    output logic                  TX_active,
    output logic                  tx_done
`ifdef SRLZR_PARITY_EN
    ,
    output logic                  parity_bit
`endif
);
    localparam int BCW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_WIDTH - 1);
    localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

    state_t         state, state_next;
    logic [BCW-1:0] bit_cnt, bit_cnt_next;
    logic           bit_end, pre_end;
    logic           load_next, shift_next, done_next;

    srlzr_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clr    (state == ST_IDLE),
        .bit_end(bit_end),
        .pre_end(pre_end)
    );

    assign tx_ready = (state == ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
        end else begin
            state   <= state_next;
            bit_cnt <= bit_cnt_next;
        end
    end

    // bit_cnt indexes data slots in DATA and stop slots in STOP
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        load_next    = 1'b0;
        shift_next   = 1'b0;
        done_next    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tx_valid) begin
                    state_next   = ST_START;
                    bit_cnt_next = '0;
                    load_next    = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_next   = ST_DATA;
                    bit_cnt_next = '0;
                end
            end
            ST_DATA: begin
                shift_next = pre_end && (bit_cnt != LAST_DATA);
                if (bit_end) begin
                    if (bit_cnt == LAST_DATA) begin
`ifdef SRLZR_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_STOP;
`endif
                        bit_cnt_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_next   = ST_STOP;
                    bit_cnt_next = '0;
                end
            end
            ST_STOP: begin
                done_next = pre_end && (bit_cnt == LAST_STOP);
                if (bit_end) begin
                    if (bit_cnt == LAST_STOP) begin
                        state_next   = ST_IDLE;
                        bit_cnt_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next   = ST_IDLE;
                bit_cnt_next = '0;
            end
        endcase
    end

    // Strobes are computed one cycle early so every output leaves a flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            piso_data <= '0;
            LOAD      <= 1'b0;
            shift     <= 1'b0;
            line_sel  <= LINE_MARK;
            TX_active <= 1'b0;
            tx_done   <= 1'b0;
`ifdef SRLZR_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            LOAD      <= load_next;
            shift     <= shift_next;
            tx_done   <= done_next;
            line_sel  <= line_code(state_next);
            TX_active <= (state_next != ST_IDLE);
            if (load_next) begin
                piso_data <= tx_data;
`ifdef SRLZR_PARITY_EN
                parity_bit <= ^tx_data;
`endif
            end
        end
    end

endmodule

// File: tb/tb_srlzr_tx_ctrl.sv
// tb/tb_srlzr_tx_ctrl.sv - scoreboard bench for srlzr_tx_ctrl; build with SRLZR_PARITY_EN for the parity variant
module tb_srlzr_tx_ctrl;
    localparam int DW  = 8;
    localparam int CPB = 4;
    localparam int SB  = 1;
`ifdef SRLZR_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NSLOT = 1 + DW + PB + SB;
    localparam int FLEN  = NSLOT * CPB;

    logic          tb_clk = 1'b0;
    logic          rst = 1'b0;
    logic          tx_valid = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          tx_ready;
    logic [DW-1:0] piso_data;
    logic          LOAD;
    logic          shift;
    logic [1:0]    line_sel;
    logic          TX_active;
    logic          tx_done;
    logic          par_w;

    always #5 tb_clk = ~tb_clk;

    srlzr_tx_ctrl #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB),
        .STOP_BITS   (SB)
    ) dut (
        .clk      (tb_clk),
        .rst      (rst),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .piso_data(piso_data),
        .LOAD     (LOAD),
        .shift    (shift),
        .line_sel (line_sel),
        .TX_active(TX_active),
        .tx_done  (tx_done)
`ifdef SRLZR_PARITY_EN
        ,
        .parity_bit(par_w)
`endif
    );
`ifndef SRLZR_PARITY_EN
    assign par_w = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
        bit            b2b;
    } rec_t;

    rec_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    always @(posedge tb_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference frame: start 0, data LSB first, optional even parity, stop ones
    function automatic logic [31:0] frame_bits(input logic [DW-1:0] d);
        logic [31:0] b;
        int k;
        b = '0;
        for (int i = 0; i < DW; i++) b[1+i] = d[i];
        k = 1 + DW;
        if (PB == 1) begin
            b[k] = ^d;
            k++;
        end
        for (int i = 0; i < SB; i++) b[k+i] = 1'b1;
        return b;
    endfunction

    // Monitor: tracks each frame from LOAD, emulates the PISO, samples mid-slot
    bit            active = 0;
    int            fc = 0;
    int            shifts = 0;
    int            last_done = -100;
    logic [DW-1:0] cur = '0;
    logic [DW-1:0] piso_m = '0;
    logic [31:0]   obs = '0;

    always @(negedge tb_clk) begin
        logic lv;
        rec_t r;
        if (rst) begin
            active = 0;
            exp_q.delete();
        end else if (LOAD) begin
            check("load_no_shift", 64'(shift), 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_load", 64'd1, 64'd0);
            end else begin
                r = exp_q.pop_front();
                check("load_latency", 64'(cyc), 64'(r.cyc + 1));
                if (r.b2b) check("b2b_gap", 64'(cyc), 64'(last_done + 2));
                check("capture", 64'(piso_data), 64'(r.data));
                if (PB == 1) check("parity_bit", 64'(par_w), 64'(^r.data));
                cur = r.data;
            end
            active = 1;
            fc = 0;
            shifts = 0;
            obs = '0;
            piso_m = piso_data;
            check("active_at_load", 64'(TX_active), 64'd1);
            check("line_at_load", 64'(line_sel), 64'd1);
            fc = 1;
        end else if (active) begin
            case (line_sel)
                2'b00:   lv = 1'b1;
                2'b01:   lv = 1'b0;
                2'b10:   lv = piso_m[0];
                default: lv = par_w;
            endcase
            if (fc % CPB == CPB / 2) obs[fc/CPB] = lv;
            check("active_hold", 64'(TX_active), 64'd1);
            check("ready_low", 64'(tx_ready), 64'd0);
            check("piso_hold", 64'(piso_data), 64'(cur));
            if (shift) begin
                check("shift_pos", 64'((fc % CPB == CPB - 1) && (fc / CPB >= 1) && (fc / CPB <= DW - 1)), 64'd1);
                shifts++;
                piso_m = piso_m >> 1;
            end
            check("done_pos", 64'(tx_done), 64'(fc == FLEN - 1));
            if (tx_done || fc >= FLEN - 1) begin
                check("frame_bits", 64'(obs), 64'(frame_bits(cur)));
                check("shift_count", 64'(shifts), 64'(DW - 1));
                last_done = cyc;
                active = 0;
            end
            fc++;
        end else begin
            check("idle_outputs", 64'({TX_active, tx_done, shift, line_sel}), 64'd0);
        end
    end

    task automatic send(input logic [DW-1:0] d, input bit b2b);
        bit ok;
        ok = 0;
        tx_valid = 1'b1;
        tx_data = d;
        for (int n = 0; n < FLEN * 3; n++) begin
            if (tx_ready) begin
                exp_q.push_back('{d, cyc, b2b});
                ok = 1;
                break;
            end
            @(negedge tb_clk);
        end
        if (!ok) check("handshake_timeout", 64'd0, 64'd1);
        @(negedge tb_clk);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int n = 0; n < FLEN * 4; n++) begin
            @(negedge tb_clk);
            #3;
            if (exp_q.size() == 0 && !active && tx_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_reset_values();
        check("rst_piso", 64'(piso_data), 64'd0);
        check("rst_strobes", 64'({LOAD, shift, tx_done, TX_active}), 64'd0);
        check("rst_line", 64'(line_sel), 64'd0);
        check("rst_ready", 64'(tx_ready), 64'd1);
        check("rst_parity", 64'(par_w), 64'd0);
    endtask

    initial begin
        int gap;
        #2 rst = 1'b1;
        #1 check_reset_values();
        repeat (3) @(negedge tb_clk);
        rst = 1'b0;
        @(negedge tb_clk);

        send(8'hA5, 0); tx_valid = 1'b0; wait_idle();
        send(8'h07, 0); tx_valid = 1'b0; wait_idle();
        send(8'h11, 0); send(8'h22, 1); tx_valid = 1'b0; wait_idle();

        send(8'h5A, 0); tx_valid = 1'b0;
        repeat (12) @(negedge tb_clk);
        tx_valid = 1'b1;
        tx_data = 8'h3C;
        check("ignore_ready", 64'(tx_ready), 64'd0);
        @(negedge tb_clk);
        tx_valid = 1'b0;
        wait_idle();

        send(8'h66, 0); tx_valid = 1'b0;
        repeat (17) @(negedge tb_clk);
        #2 rst = 1'b1;
        #1 check_reset_values();
        @(negedge tb_clk);
        #2 rst = 1'b0;
        send(8'h81, 0); tx_valid = 1'b0; wait_idle();

        gap = 1;
        for (int i = 0; i < 40; i++) begin
            send(DW'($urandom), (gap == 0));
            gap = $urandom_range(0, 3);
            if (gap != 0) begin
                tx_valid = 1'b0;
                repeat (gap) @(negedge tb_clk);
            end
        end
        tx_valid = 1'b0;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
